fifo_ctrl_syn: RTL and testbench

FIFO_CTRL_SYN -- requirements
Module: fifo_ctrl_syn

---
 rtl/fifo_syn_pkg.sv | 6 +
 rtl/dual_port_syn.sv | 36 +++
 rtl/fifo_syn.sv | 58 +++++
 rtl/fifo_ctrl_syn.sv | 87 ++++++++
 tb/tb_fifo_ctrl_syn.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_syn_pkg.sv
// Default geometry shared by the FIFO controller, its dual-port memory and the integration top.
package fifo_syn_pkg;
   localparam int WI  = 8;
   localparam int DEP = 16;
   localparam int ADD = 4;
endpackage : fifo_syn_pkg

// File: rtl/dual_port_syn.sv
// Synchronous dual-port memory with a registered read port; one-cycle read latency.
// A cycle with both strobes high performs neither access. Rst clears contents and dout.
module dual_port_syn
   import fifo_syn_pkg::*;
#(
   parameter int wi  = WI,
   parameter int dep = DEP,
   parameter int add = ADD
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wr,
   input  logic           rd,
   input  logic [add-1:0] wa,
   input  logic [add-1:0] ra,
   input  logic [wi-1:0]  din,
   output logic [wi-1:0]  dout
);
   logic [wi-1:0] mem_q [dep];
   logic [wi-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < dep; i++) begin
            mem_q[i] <= '0;
         end
         dout_q <= '0;
      end else if (wr && !rd) begin
         mem_q[wa] <= din;
      end else if (rd && !wr) begin
         dout_q <= mem_q[ra];
      end
   end

   assign dout = dout_q;
endmodule : dual_port_syn

// File: rtl/fifo_syn.sv
// Integration top: FIFO controller plus its dual-port memory on a shared clk/rst.
// Popped data appears on dout when rd_valid is high, one cycle after pop_ack.
module fifo_syn
   import fifo_syn_pkg::*;
#(
   parameter int wi  = WI,
   parameter int dep = DEP,
   parameter int add = ADD
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_valid,
   input  logic [wi-1:0] push_data,
   output logic          push_ready,
   input  logic          pop_req,
   output logic          pop_ack,
   output logic          rd_valid,
   output logic [wi-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [add:0]  count,
   output logic          err_udf
);
   logic           mem_wr, mem_rd;
   logic [add-1:0] mem_wa, mem_ra;
   logic [wi-1:0]  mem_din;

   fifo_ctrl_syn #(.wi(wi), .dep(dep), .add(add)) u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_ready (push_ready),
      .pop_req    (pop_req),
      .pop_ack    (pop_ack),
      .rd_valid   (rd_valid),
      .mem_wr     (mem_wr),
      .mem_rd     (mem_rd),
      .mem_wa     (mem_wa),
      .mem_ra     (mem_ra),
      .mem_din    (mem_din),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .err_udf    (err_udf)
   );

   dual_port_syn #(.wi(wi), .dep(dep), .add(add)) u_mem (
      .clk  (clk),
      .rst  (rst),
      .wr   (mem_wr),
      .rd   (mem_rd),
      .wa   (mem_wa),
      .ra   (mem_ra),
      .din  (mem_din),
      .dout (dout)
   );
endmodule : fifo_syn

// File: rtl/fifo_ctrl_syn.sv
// FIFO controller driving an external synchronous dual-port memory; read data arrives one cycle after pop_ack.
// A granted pop blocks a push in the same cycle; pushes stall while full, pops on empty set a sticky error.
module fifo_ctrl_syn
   import fifo_syn_pkg::*;
#(
   parameter int wi  = WI,
   parameter int dep = DEP,
   parameter int add = ADD
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push_valid,
   input  logic [wi-1:0]  push_data,
   output logic           push_ready,
   input  logic           pop_req,
   output logic           pop_ack,
   output logic           rd_valid,
   output logic           mem_wr,
   output logic           mem_rd,
   output logic [add-1:0] mem_wa,
   output logic [add-1:0] mem_ra,
   output logic [wi-1:0]  mem_din,
   output logic           full,
   output logic           empty,
   output logic [add:0]   count,
   output logic           err_udf
);
   localparam logic [add:0] CNT_FULL = (add+1)'(dep);

   logic [add-1:0] wr_ptr_q, wr_ptr_d;
   logic [add-1:0] rd_ptr_q, rd_ptr_d;
   logic [add:0]   count_q, count_d;
   logic           rd_valid_q;
   logic           err_udf_q, err_udf_d;
   logic           push_acc;

   assign empty      = (count_q == '0);
   assign full       = (count_q == CNT_FULL);
   assign pop_ack    = pop_req && !empty && !rst;
   assign push_ready = !full && !pop_ack && !rst;
   assign push_acc   = push_valid && push_ready;

   assign mem_wr  = push_acc;
   assign mem_rd  = pop_ack;
   assign mem_wa  = wr_ptr_q;
   assign mem_ra  = rd_ptr_q;
   assign mem_din = push_data;

   assign count    = count_q;
   assign rd_valid = rd_valid_q;
   assign err_udf  = err_udf_q;

   // Push and pop are mutually exclusive, so count moves by at most one per cycle.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      err_udf_d = err_udf_q;
      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + add'(1);
         count_d  = count_q + (add+1)'(1);
      end
      if (pop_ack) begin
         rd_ptr_d = rd_ptr_q + add'(1);
         count_d  = count_q - (add+1)'(1);
      end
      if (pop_req && empty) begin
         err_udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         err_udf_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= pop_ack;
         err_udf_q  <= err_udf_d;
      end
   end
endmodule : fifo_ctrl_syn

// File: tb/tb_fifo_ctrl_syn.sv
// Directed plus randomized bench for fifo_ctrl_syn with a queue-based reference model.
module tb_fifo_ctrl_syn;
   localparam int DEPTH = 16;
   localparam int TIMEOUT_NS = 200000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push_valid = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       pop_req = 1'b0;
   logic       push_ready, pop_ack, rd_valid;
   logic       mem_wr, mem_rd;
   logic [3:0] mem_wa, mem_ra;
   logic [7:0] mem_din, dout;
   logic       full, empty, err_udf;
   logic [4:0] count;

   int vectors = 0;
   int miscompares = 0;
   bit done = 1'b0;

   // reference model state
   logic [7:0] mq[$];
   int         wcnt = 0;
   int         rcnt = 0;
   logic       m_err = 1'b0;
   logic       m_rdv = 1'b0;
   logic [7:0] m_dout = 8'h00;

   always #5 clk = ~clk;

   fifo_ctrl_syn dut (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_ready (push_ready),
      .pop_req    (pop_req),
      .pop_ack    (pop_ack),
      .rd_valid   (rd_valid),
      .mem_wr     (mem_wr),
      .mem_rd     (mem_rd),
      .mem_wa     (mem_wa),
      .mem_ra     (mem_ra),
      .mem_din    (mem_din),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .err_udf    (err_udf)
   );

   dual_port_syn u_mem (
      .clk  (clk),
      .rst  (rst),
      .wr   (mem_wr),
      .rd   (mem_rd),
      .wa   (mem_wa),
      .ra   (mem_ra),
      .din  (mem_din),
      .dout (dout)
   );

   task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, advance model at posedge, check state.
   task automatic step(input logic pv, input logic [7:0] pd, input logic pr, input logic r);
      logic exp_ack, exp_rdy, exp_wr, was_empty;
      logic [4:0] exp_cnt;
      @(negedge clk);
      push_valid = pv;
      push_data  = pd;
      pop_req    = pr;
      rst        = r;
      #1;
      was_empty = (mq.size() == 0);
      exp_ack   = pr && !was_empty && !r;
      exp_rdy   = (mq.size() < DEPTH) && !exp_ack && !r;
      exp_wr    = pv && exp_rdy;
      vectors++;
      if (pop_ack !== exp_ack) fail("pop_ack", pop_ack, exp_ack);
      vectors++;
      if (push_ready !== exp_rdy) fail("push_ready", push_ready, exp_rdy);
      vectors++;
      if (mem_wr !== exp_wr) fail("mem_wr", mem_wr, exp_wr);
      vectors++;
      if (mem_rd !== exp_ack) fail("mem_rd", mem_rd, exp_ack);
      vectors++;
      if (mem_din !== pd) fail("mem_din", mem_din, pd);
      if (!r) begin
         vectors++;
         if (mem_wa !== 4'(wcnt % DEPTH)) fail("mem_wa", mem_wa, 4'(wcnt % DEPTH));
         vectors++;
         if (mem_ra !== 4'(rcnt % DEPTH)) fail("mem_ra", mem_ra, 4'(rcnt % DEPTH));
      end
      @(posedge clk);
      if (r) begin
         mq.delete();
         wcnt  = 0;
         rcnt  = 0;
         m_err = 1'b0;
         m_rdv = 1'b0;
      end else begin
         m_rdv = exp_ack;
         if (exp_ack) begin
            m_dout = mq.pop_front();
            rcnt++;
         end
         if (exp_wr) begin
            mq.push_back(pd);
            wcnt++;
         end
         if (pr && was_empty) m_err = 1'b1;
      end
      #1;
      exp_cnt = 5'(mq.size());
      vectors++;
      if (count !== exp_cnt) fail("count", count, exp_cnt);
      vectors++;
      if (empty !== (mq.size() == 0)) fail("empty", empty, (mq.size() == 0));
      vectors++;
      if (full !== (mq.size() == DEPTH)) fail("full", full, (mq.size() == DEPTH));
      vectors++;
      if (err_udf !== m_err) fail("err_udf", err_udf, m_err);
      vectors++;
      if (rd_valid !== m_rdv) fail("rd_valid", rd_valid, m_rdv);
      if (m_rdv) begin
         vectors++;
         if (dout !== m_dout) fail("dout", dout, m_dout);
      end
   endtask

   initial begin
      #(TIMEOUT_NS);
      if (!done) begin
         miscompares++;
         $error("FAIL timeout: stimulus did not complete within %0d ns", TIMEOUT_NS);
         $finish;
      end
   end

   initial begin
      // reset, then three pushes and three pops
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      vectors++;
      if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || err_udf !== 1'b0 || rd_valid !== 1'b0) begin
         miscompares++;
         $error("FAIL reset_state: count=%0h empty=%0b full=%0b err_udf=%0b rd_valid=%0b",
                count, empty, full, err_udf, rd_valid);
      end
      step(1'b1, 8'hA1, 1'b0, 1'b0);
      step(1'b1, 8'hA2, 1'b0, 1'b0);
      step(1'b1, 8'hA3, 1'b0, 1'b0);
      vectors++;
      if (count !== 5'd3) fail("cnt_after3", count, 5'd3);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (empty !== 1'b1) fail("empty_after3", empty, 1'b1);

      // fill to full, then a rejected 17th push
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      vectors++;
      if (full !== 1'b1) fail("full16", full, 1'b1);
      step(1'b1, 8'h10, 1'b0, 1'b0);
      vectors++;
      if (count !== 5'd16) fail("cnt_stall16", count, 5'd16);

      // drain to 5, then simultaneous push and pop
      for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (count !== 5'd5) fail("cnt5", count, 5'd5);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      vectors++;
      if (count !== 5'd4) fail("cnt_pp4", count, 5'd4);

      // drain, underflow, sticky through idle, cleared by reset
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
      vectors++;
      if (err_udf !== 1'b1) fail("udf_sticky", err_udf, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      vectors++;
      if (err_udf !== 1'b0) fail("udf_clear", err_udf, 1'b0);

      // fill, partial drain, refill across the pointer wrap, reset while full
      for (int i = 0; i < 16; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
      vectors++;
      if (count !== 5'd16) fail("cnt_wrap16", count, 5'd16);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b1, 1'b1);
      vectors++;
      if (count !== 5'd0) fail("cnt_rst", count, 5'd0);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 63) == 0));
      end
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      done = 1'b1;
      if (miscompares != 0) begin
         $error("FAIL summary: %0d miscompares over %0d vectors", miscompares, vectors);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule : tb_fifo_ctrl_syn
